// File: rtl/blob_width_packer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : blob_width_packer_pkg
//  Description : Shared layer-datapath constants. Beat widths, the element
//                (lane) width and the derived input-to-output width ratio are
//                used by every blob layer block so they agree on packing.
//  Revision    : 1.0 - initial release
// ============================================================================
package blob_width_packer_pkg;

    localparam int BLOB_DIN_DW  = 64;
    localparam int BLOB_DOUT_DW = 512;
    localparam int BLOB_LANE_DW = 16;
    localparam int BLOB_RATIO   = BLOB_DOUT_DW / BLOB_DIN_DW;

    // Occupancy of the two-entry output queue (0, 1 or 2).
    typedef logic [1:0] fifo_cnt_t;

    localparam fifo_cnt_t C_FIFO_DEPTH = 2'd2;

    // Width of a counter that indexes RATIO beats; never narrower than 1 bit.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage : blob_width_packer_pkg
`default_nettype wire

// File: rtl/blob_width_packer_skid_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : blob_skid_fifo
//  Description : Two-entry FIFO holding packed words (data + eop flag) on
//                their way to the downstream row buffer.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous, active-low reset
//                push       - write push_data (ignored when full)
//                push_data  - word to enqueue
//                pop        - drop the head entry (ignored when empty)
//                head_data  - current head entry (zero while reset/unused)
//                empty/full - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module blob_skid_fifo
    import blob_width_packer_pkg::*;
#(
    parameter int WIDTH = BLOB_DOUT_DW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q;
    logic             wr_ptr_d;
    logic             rd_ptr_q;
    logic             rd_ptr_d;
    fifo_cnt_t        count_q;
    fifo_cnt_t        count_d;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        w_do_push = push & (count_q != C_FIFO_DEPTH);
        w_do_pop  = pop & (count_q != 2'd0);

        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == 2'd0);
    assign full      = (count_q == C_FIFO_DEPTH);

endmodule : blob_skid_fifo
`default_nettype wire

// File: rtl/blob_width_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : blob_width_packer
//  Description : Packs RATIO narrow layer-output beats into one wide word for
//                the next layer's row buffer, optionally applying ReLU on each
//                fixed-point lane. Short frames (eop before RATIO beats) are
//                zero-filled. Words leave through a two-entry FIFO.
//  Ports       : clk            - clock, rising edge
//                rst            - asynchronous, active-low reset
//                blob_din       - input beat (DIN_DW)
//                blob_din_en    - input beat valid
//                blob_din_eop   - input beat is last of frame
//                blob_din_rdy   - packer accepts a beat this cycle
//                blob_dout      - packed word (DOUT_DW), beat 0 in the LSBs
//                blob_dout_en   - packed word valid
//                blob_dout_eop  - packed word is last of frame
//                blob_dout_rdy  - downstream accepts a word this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module blob_width_packer
    import blob_width_packer_pkg::*;
#(
    parameter int DIN_DW  = BLOB_DIN_DW,
    parameter int DOUT_DW = BLOB_DOUT_DW,
    parameter int LANE_DW = BLOB_LANE_DW,
    parameter int RELU    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIN_DW-1:0]  blob_din,
    input  logic               blob_din_en,
    input  logic               blob_din_eop,
    output logic               blob_din_rdy,
    output logic [DOUT_DW-1:0] blob_dout,
    output logic               blob_dout_en,
    output logic               blob_dout_eop,
    input  logic               blob_dout_rdy
);

    localparam int RATIO = DOUT_DW / DIN_DW;
    localparam int NLANE = DIN_DW / LANE_DW;
    localparam int CNT_W = cnt_width(RATIO);

    localparam logic [CNT_W-1:0] C_LAST_LANE = CNT_W'(RATIO - 1);

    logic [DIN_DW-1:0]  w_din_act;
    logic               w_accept;
    logic               w_push;
    logic [DOUT_DW-1:0] w_word_ins;
    logic [DOUT_DW-1:0] word_q;
    logic [DOUT_DW-1:0] word_d;
    logic [CNT_W-1:0]   lane_q;
    logic [CNT_W-1:0]   lane_d;
    logic               w_fifo_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [DOUT_DW:0]   w_fifo_head;

    // ------------------------------------------------------------------
    // Per-lane activation: a set MSB marks a negative fixed-point value.
    // ------------------------------------------------------------------
    generate
        if (RELU != 0) begin : g_relu
            for (genvar l = 0; l < NLANE; l++) begin : g_lane
                assign w_din_act[l*LANE_DW +: LANE_DW] =
                    blob_din[l*LANE_DW + LANE_DW - 1] ? '0
                                                      : blob_din[l*LANE_DW +: LANE_DW];
            end
        end else begin : g_pass
            assign w_din_act = blob_din;
        end
    endgenerate

    assign w_accept = blob_din_en & blob_din_rdy;

    // ------------------------------------------------------------------
    // Packing datapath. The partial word is cleared after every push, so
    // lanes not yet written are already zero: a short frame is zero-filled
    // simply by pushing the partial word with the current beat inserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_word_ins = word_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_q == CNT_W'(k)) begin
                w_word_ins[k*DIN_DW +: DIN_DW] = w_din_act;
            end
        end

        w_push = w_accept & (blob_din_eop | (lane_q == C_LAST_LANE));

        word_d = word_q;
        lane_d = lane_q;
        if (w_accept) begin
            if (w_push) begin
                word_d = '0;
                lane_d = '0;
            end else begin
                word_d = w_word_ins;
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    // ------------------------------------------------------------------
    // Output queue. Accepting only while not full guarantees every push
    // lands, so no back-pressure path into the packing logic is needed.
    // ------------------------------------------------------------------
    assign w_fifo_pop = blob_dout_en & blob_dout_rdy;

    blob_skid_fifo #(
        .WIDTH     (DOUT_DW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({blob_din_eop, w_word_ins}),
        .pop       (w_fifo_pop),
        .head_data (w_fifo_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    // Gating with rst keeps rdy low while reset is held and lets it rise in
    // the very first cycle after release.
    assign blob_din_rdy  = rst & ~w_fifo_full;
    assign blob_dout_en  = ~w_fifo_empty;
    assign blob_dout     = w_fifo_head[DOUT_DW-1:0];
    assign blob_dout_eop = w_fifo_head[DOUT_DW];

endmodule : blob_width_packer
`default_nettype wire
